apb_arb_master: RTL and testbench

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_arb_master.sv | 144 ++++++++++++++
 tb/tb_apb_arb_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration in front of a single
// IDLE/SETUP/ACCESS transfer engine driving two slaves, with a wait-state timeout.
module apb_arb_master #(
  parameter int TIMEOUT = 15
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       req0_valid,
  input  logic       req0_write,
  input  logic [8:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic [3:0] req0_strb,
  input  logic       req1_valid,
  input  logic       req1_write,
  input  logic [8:0] req1_addr,
  input  logic [7:0] req1_wdata,
  input  logic [3:0] req1_strb,
  output logic [1:0] ack,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  output logic [3:0] PSTRB,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY1,
  input  logic       PREADY2
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t     state, nextState;
  logic       owner;
  logic       pref;
  logic       slaveSel;
  logic       anyReq;
  logic       winner;
  logic       selReady;
  logic [7:0] selRdata;
  logic [7:0] waitCnt;
  logic       timeoutHit;
  logic       capWrite;
  logic [8:0] capAddr;
  logic [7:0] capWdata;
  logic [3:0] capStrb;

  // pref names the requester that wins a tie; it flips to the loser on every grant
  assign anyReq   = req0_valid | req1_valid;
  assign winner   = (req0_valid & req1_valid) ? pref : req1_valid;
  assign capWrite = winner ? req1_write : req0_write;
  assign capAddr  = winner ? req1_addr  : req0_addr;
  assign capWdata = winner ? req1_wdata : req0_wdata;
  assign capStrb  = winner ? req1_strb  : req0_strb;

  assign selReady   = slaveSel ? PREADY2 : PREADY1;
  assign selRdata   = slaveSel ? PRDATA2 : PRDATA1;
  // waitCnt holds the low-PREADY cycles already seen, so the current one is the TIMEOUT-th
  assign timeoutHit = (waitCnt == 8'(TIMEOUT - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    ack       = 2'b00;
    PSEL1     = 1'b0;
    PSEL2     = 1'b0;
    PENABLE   = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) nextState = SETUP;
      end
      SETUP: begin
        ack       = owner ? 2'b10 : 2'b01;
        PSEL1     = ~slaveSel;
        PSEL2     = slaveSel;
        nextState = ACCESS;
      end
      ACCESS: begin
        PSEL1   = ~slaveSel;
        PSEL2   = slaveSel;
        PENABLE = 1'b1;
        if (selReady || timeoutHit) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Request capture, wait counting and the registered completion outputs
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      owner    <= 1'b0;
      pref     <= 1'b0;
      slaveSel <= 1'b0;
      waitCnt  <= 8'd0;
      PWRITE   <= 1'b0;
      PADDR    <= 8'd0;
      PWDATA   <= 8'd0;
      PSTRB    <= 4'd0;
      done     <= 2'b00;
      rdata    <= 8'd0;
      err      <= 1'b0;
    end else begin
      done <= 2'b00;
      case (state)
        IDLE: begin
          if (anyReq) begin
            owner    <= winner;
            pref     <= ~winner;
            slaveSel <= capAddr[8];
            PWRITE   <= capWrite;
            PADDR    <= capAddr[7:0];
            PWDATA   <= capWdata;
            PSTRB    <= capWrite ? capStrb : 4'b0000;
          end
        end
        SETUP: begin
          waitCnt <= 8'd0;
        end
        ACCESS: begin
          if (selReady) begin
            done <= owner ? 2'b10 : 2'b01;
            err  <= 1'b0;
            if (!PWRITE) rdata <= selRdata;
          end else if (timeoutHit) begin
            done <= owner ? 2'b10 : 2'b01;
            err  <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: transfer-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_apb_arb_master;

  localparam int TIMEOUT = 15;

  logic       PCLK, PRESET;
  logic       req0_valid, req0_write, req1_valid, req1_write;
  logic [8:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic [3:0] req0_strb, req1_strb;
  logic [1:0] ack, done;
  logic [7:0] rdata;
  logic       err;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [3:0] PSTRB;
  logic [7:0] PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  apb_arb_master #(.TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_strb(req0_strb),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_strb(req1_strb),
    .ack(ack), .done(done), .rdata(rdata), .err(err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  initial PCLK = 0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: a transfer is busy from grant until completion; the
  // first busy cycle is the setup phase, the rest are access cycles.
  logic       mBusy, mAccess, mOwner, mPref, mWrite, mSlave, mErr;
  int         mWaits;
  logic [7:0] mAddr, mWdata, mRdata;
  logic [3:0] mStrb;
  logic [1:0] mDone;
  logic       mWin;
  logic [8:0] mWinAddr;

  assign mWin     = (req0_valid && req1_valid) ? mPref : req1_valid;
  assign mWinAddr = mWin ? req1_addr : req0_addr;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      mBusy <= 0; mAccess <= 0; mWaits <= 0; mOwner <= 0; mPref <= 0;
      mWrite <= 0; mSlave <= 0; mAddr <= 0; mWdata <= 0; mStrb <= 0;
      mDone <= 0; mRdata <= 0; mErr <= 0;
    end else begin
      mDone <= 2'b00;
      if (!mBusy) begin
        if (req0_valid || req1_valid) begin
          mBusy   <= 1;
          mAccess <= 0;
          mOwner  <= mWin;
          mPref   <= !mWin;
          mWrite  <= mWin ? req1_write : req0_write;
          mSlave  <= (mWinAddr >= 9'h100);
          mAddr   <= mWinAddr[7:0];
          mWdata  <= mWin ? req1_wdata : req0_wdata;
          mStrb   <= (mWin ? req1_write : req0_write) ? (mWin ? req1_strb : req0_strb) : 4'h0;
        end
      end else if (!mAccess) begin
        mAccess <= 1;
        mWaits  <= 0;
      end else if (mSlave ? PREADY2 : PREADY1) begin
        mBusy <= 0; mAccess <= 0;
        mDone <= mOwner ? 2'b10 : 2'b01;
        mErr  <= 0;
        if (!mWrite) mRdata <= mSlave ? PRDATA2 : PRDATA1;
      end else if (mWaits + 1 == TIMEOUT) begin
        mBusy <= 0; mAccess <= 0;
        mDone <= mOwner ? 2'b10 : 2'b01;
        mErr  <= 1;
      end else begin
        mWaits <= mWaits + 1;
      end
    end
  end

  always @(negedge PCLK) begin
    if (checkEn && !PRESET) begin
      checkOutput("psel1", 32'(PSEL1), 32'(mBusy && !mSlave));
      checkOutput("psel2", 32'(PSEL2), 32'(mBusy && mSlave));
      checkOutput("pselExclusive", 32'(PSEL1 && PSEL2), 32'(0));
      checkOutput("penable", 32'(PENABLE), 32'(mBusy && mAccess));
      checkOutput("ack", 32'(ack), 32'((mBusy && !mAccess) ? (mOwner ? 2'b10 : 2'b01) : 2'b00));
      checkOutput("done", 32'(done), 32'(mDone));
      checkOutput("pwrite", 32'(PWRITE), 32'(mWrite));
      checkOutput("paddr", 32'(PADDR), 32'(mAddr));
      checkOutput("pwdata", 32'(PWDATA), 32'(mWdata));
      checkOutput("pstrb", 32'(PSTRB), 32'(mStrb));
      checkOutput("rdata", 32'(rdata), 32'(mRdata));
      checkOutput("err", 32'(err), 32'(mErr));
    end
  end

  task automatic applyStimulus(input logic r, input logic valid, input logic write,
                               input logic [8:0] addr, input logic [7:0] wdata,
                               input logic [3:0] strb);
    if (r) begin
      req1_valid = valid; req1_write = write; req1_addr = addr;
      req1_wdata = wdata; req1_strb = strb;
    end else begin
      req0_valid = valid; req0_write = write; req0_addr = addr;
      req0_wdata = wdata; req0_strb = strb;
    end
  endtask

  task automatic waitAck(input logic [1:0] expAck, input string name);
    int n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (ack == 2'b00 && n < 20);
    checkOutput(name, 32'(ack), 32'(expAck));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int n;
    logic [1:0] arbExp [12];

    PRESET = 1;
    applyStimulus(0, 0, 0, 9'h0, 8'h0, 4'h0);
    applyStimulus(1, 0, 0, 9'h0, 8'h0, 4'h0);
    PRDATA1 = 8'h0; PRDATA2 = 8'h0; PREADY1 = 1; PREADY2 = 1;

    repeat (2) @(negedge PCLK);
    checkOutput("rstAck", 32'(ack), 32'(0));
    checkOutput("rstPsel", 32'({PSEL1, PSEL2, PENABLE}), 32'(0));
    checkOutput("rstDone", 32'(done), 32'(0));
    checkOutput("rstRdata", 32'(rdata), 32'(0));
    #2 PRESET = 0;
    checkEn = 1;

    // Write to slave1 from req0
    @(negedge PCLK);
    applyStimulus(0, 1, 1, 9'h005, 8'hA5, 4'hF);
    waitAck(2'b01, "wrAck");
    checkOutput("wrSetupSel", 32'({PSEL1, PSEL2, PENABLE}), 32'(3'b100));
    checkOutput("wrPaddr", 32'(PADDR), 32'(8'h05));
    checkOutput("wrPwdata", 32'(PWDATA), 32'(8'hA5));
    checkOutput("wrPstrb", 32'(PSTRB), 32'(4'hF));
    checkOutput("wrPwrite", 32'(PWRITE), 32'(1));
    req0_valid = 0;
    @(negedge PCLK);
    checkOutput("wrAccessSel", 32'({PSEL1, PSEL2, PENABLE}), 32'(3'b101));
    @(negedge PCLK);
    checkOutput("wrDone", 32'(done), 32'(2'b01));
    checkOutput("wrErr", 32'(err), 32'(0));

    // Read from slave2 from req1; slave1 data must be ignored
    PRDATA1 = 8'h99; PRDATA2 = 8'h3C;
    applyStimulus(1, 1, 0, 9'h105, 8'h00, 4'hF);
    waitAck(2'b10, "rdAck");
    checkOutput("rdSetupSel", 32'({PSEL1, PSEL2, PENABLE}), 32'(3'b010));
    checkOutput("rdPstrb", 32'(PSTRB), 32'(0));
    checkOutput("rdPaddr", 32'(PADDR), 32'(8'h05));
    req1_valid = 0;
    repeat (2) @(negedge PCLK);
    checkOutput("rdDone", 32'(done), 32'(2'b10));
    checkOutput("rdRdata", 32'(rdata), 32'(8'h3C));
    checkOutput("rdErr", 32'(err), 32'(0));

    // Timeout: slave1 never ready, slave2 ready but unselected
    PREADY1 = 0; PREADY2 = 1; PRDATA1 = 8'h77;
    applyStimulus(0, 1, 0, 9'h010, 8'h00, 4'h0);
    waitAck(2'b01, "toAck");
    req0_valid = 0;
    cnt = 0; n = 0;
    while (done == 2'b00 && n < 40) begin
      @(negedge PCLK);
      n++;
      if (PENABLE) cnt++;
    end
    checkOutput("toAccessCycles", 32'(cnt), 32'(15));
    checkOutput("toDone", 32'(done), 32'(2'b01));
    checkOutput("toErr", 32'(err), 32'(1));
    checkOutput("toRdataKept", 32'(rdata), 32'(8'h3C));

    // Three wait states on slave1, then ready
    applyStimulus(1, 1, 1, 9'h0AA, 8'h5A, 4'h3);
    waitAck(2'b10, "wsAck");
    req1_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge PCLK);
      checkOutput("wsPenable", 32'(PENABLE), 32'(1));
      checkOutput("wsPaddr", 32'(PADDR), 32'(8'hAA));
      checkOutput("wsPwdata", 32'(PWDATA), 32'(8'h5A));
      checkOutput("wsPstrb", 32'(PSTRB), 32'(4'h3));
      if (i == 4) PREADY1 = 1;
    end
    @(negedge PCLK);
    checkOutput("wsDone", 32'(done), 32'(2'b10));
    checkOutput("wsErr", 32'(err), 32'(0));

    // Reset during ACCESS; req1 would win next without the reset
    PREADY1 = 0;
    applyStimulus(0, 1, 1, 9'h022, 8'h99, 4'hF);
    waitAck(2'b01, "rstTestAck");
    applyStimulus(1, 1, 0, 9'h1BB, 8'h00, 4'h0);
    PRDATA2 = 8'h44;
    @(negedge PCLK);
    #2 PRESET = 1;
    #1;
    checkOutput("midRstSel", 32'({PSEL1, PSEL2, PENABLE, PWRITE}), 32'(0));
    checkOutput("midRstBus", 32'({PADDR, PWDATA, PSTRB}), 32'(0));
    checkOutput("midRstAckDone", 32'({ack, done}), 32'(0));
    checkOutput("midRstRdErr", 32'({rdata, err}), 32'(0));
    @(negedge PCLK);
    checkOutput("midRstNoDone", 32'(done), 32'(0));
    PREADY1 = 1;
    #2 PRESET = 0;

    // Both requests held: grants alternate from req0 every 3 cycles
    for (int k = 0; k < 12; k++) arbExp[k] = 2'b00;
    arbExp[0] = 2'b01; arbExp[3] = 2'b10; arbExp[6] = 2'b01; arbExp[9] = 2'b10;
    for (int k = 0; k < 12; k++) begin
      @(negedge PCLK);
      checkOutput("arbAck", 32'(ack), 32'(arbExp[k]));
    end
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge PCLK);
    checkOutput("arbLastRdata", 32'(rdata), 32'(8'h44));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
